mem_access_unit: RTL and testbench

//  MEM-stage initiator for the unified memory's data port (mem_* pins). Accepts one load/store request
//  at a time and drives the memory address, write data and write enable. Returns load data or store completion.

---
 rtl/mips_mem_pkg.sv | 40 ++++
 rtl/lsu_align.sv | 79 +++++++
 rtl/mem_access_unit.sv | 133 +++++++++++++
 tb/tb_mem_access_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage memory access unit.
//   - load/store op codes carried on req_op
//   - FSM state encoding for mem_access_unit
//   - helpers to classify an op as a load or a store
// Op codes above OP_SWR are not assigned and behave as LW.
package mips_mem_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_LW  = 4'd0;
  localparam logic [OP_W-1:0] OP_LH  = 4'd1;
  localparam logic [OP_W-1:0] OP_LHU = 4'd2;
  localparam logic [OP_W-1:0] OP_LB  = 4'd3;
  localparam logic [OP_W-1:0] OP_LBU = 4'd4;
  localparam logic [OP_W-1:0] OP_LWL = 4'd5;
  localparam logic [OP_W-1:0] OP_LWR = 4'd6;
  localparam logic [OP_W-1:0] OP_SW  = 4'd7;
  localparam logic [OP_W-1:0] OP_SH  = 4'd8;
  localparam logic [OP_W-1:0] OP_SB  = 4'd9;
  localparam logic [OP_W-1:0] OP_SWL = 4'd10;
  localparam logic [OP_W-1:0] OP_SWR = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Expects an already normalised op (unassigned codes mapped to OP_LW).
  function automatic logic is_store(input logic [OP_W-1:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB) ||
           (op == OP_SWL) || (op == OP_SWR);
  endfunction

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return !is_store(op);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for loads and stores on a big-endian word.
// Ports:
//   op          in   4   normalised op code
//   k           in   2   byte offset inside the aligned word
//   w           in   32  aligned word read from memory
//   wdata       in   32  store data (rt)
//   rt_old      in   32  current rt, merge source for LWL/LWR
//   load_result out  32  value returned to the pipeline (0 for stores)
//   store_word  out  32  full word to write back for stores
//   misaligned  out  1   word/halfword access not naturally aligned
module lsu_align
  import mips_mem_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [1:0]      k,
  input  logic [31:0]     w,
  input  logic [31:0]     wdata,
  input  logic [31:0]     rt_old,
  output logic [31:0]     load_result,
  output logic [31:0]     store_word,
  output logic            misaligned
);

  // s: bit distance of byte k from the MSB; t: distance from the LSB.
  logic [4:0]  s;
  logic [4:0]  t;
  logic [4:0]  h_sh;
  logic [7:0]  byte_k;
  logic [15:0] half_k;
  logic [31:0] byte_mask;
  logic [31:0] half_mask;

  always_comb begin
    s         = {k, 3'b000};
    t         = {~k, 3'b000};
    // Halfword at k sits 16-s bits above the LSB (k is 0 or 2 when legal).
    h_sh      = 5'd16 - s;
    byte_k    = 8'(w >> t);
    half_k    = 16'(w >> h_sh);
    byte_mask = 32'h0000_00FF << t;
    half_mask = 32'h0000_FFFF << h_sh;
  end

  always_comb begin
    misaligned = 1'b0;
    case (op)
      OP_LW, OP_SW:          misaligned = (k != 2'd0);
      OP_LH, OP_LHU, OP_SH:  misaligned = k[0];
      default:               misaligned = 1'b0;
    endcase
  end

  always_comb begin
    load_result = w;
    case (op)
      OP_LB:   load_result = {{24{byte_k[7]}}, byte_k};
      OP_LBU:  load_result = {24'd0, byte_k};
      OP_LH:   load_result = {{16{half_k[15]}}, half_k};
      OP_LHU:  load_result = {16'd0, half_k};
      OP_LWL:  load_result = (w << s) | (rt_old & ((32'd1 << s) - 32'd1));
      OP_LWR:  load_result = (w >> t) | (rt_old & ~(32'hFFFF_FFFF >> t));
      OP_SW, OP_SH, OP_SB, OP_SWL, OP_SWR: load_result = 32'd0;
      default: load_result = w;
    endcase
  end

  always_comb begin
    store_word = w;
    case (op)
      OP_SW:   store_word = wdata;
      OP_SB:   store_word = (w & ~byte_mask) | ({24'd0, wdata[7:0]} << t);
      OP_SH:   store_word = (w & ~half_mask) | ({16'd0, wdata[15:0]} << h_sh);
      OP_SWL:  store_word = (w & ~(32'hFFFF_FFFF >> s)) | (wdata >> s);
      OP_SWR:  store_word = (wdata << t) | (w & ~(32'hFFFF_FFFF << t));
      default: store_word = w;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the unified memory data port. One load/store in
// flight at a time; sub-word and unaligned stores are read-modify-write on
// the aligned word. All memory-side outputs are registered so the write
// strobe is clean for exactly one cycle.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake (ready only when idle)
//   req_op/addr/wdata/rt_old       request payload
//   resp_valid/resp_rdata/resp_err one-cycle completion with load data/error
//   mem_addr/mem_din/mem_wr_en     registered drive to memory
//   mem_dout                       combinational read data from memory
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int AW  = 32,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [OPW-1:0] req_op,
  input  logic [AW-1:0]  req_addr,
  input  logic [31:0]    req_wdata,
  input  logic [31:0]    req_rt_old,
  output logic           resp_valid,
  output logic [31:0]    resp_rdata,
  output logic           resp_err,
  output logic [AW-1:0]  mem_addr,
  output logic [31:0]    mem_din,
  output logic           mem_wr_en,
  input  logic [31:0]    mem_dout
);

  state_t          state;
  state_t          state_nx;
  logic [OP_W-1:0] op_in;
  logic [OP_W-1:0] op_q;
  logic [1:0]      k_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rt_old_q;
  logic [OP_W-1:0] al_op;
  logic [1:0]      al_k;
  logic [31:0]     load_result;
  logic [31:0]     store_word;
  logic            misaligned;
  logic            accept;

  // Unassigned op codes collapse to LW before anything looks at them.
  always_comb begin
    op_in = (32'(req_op) > 32'(OP_SWR)) ? OP_LW : OP_W'(req_op);
  end

  assign req_ready = (state == ST_IDLE);
  assign accept    = (state == ST_IDLE) && req_valid;

  // While idle the aligner checks the incoming request for misalignment;
  // afterwards it works on the latched request and the read word.
  always_comb begin
    if (state == ST_IDLE) begin
      al_op = op_in;
      al_k  = req_addr[1:0];
    end else begin
      al_op = op_q;
      al_k  = k_q;
    end
  end

  lsu_align u_align (
    .op          (al_op),
    .k           (al_k),
    .w           (mem_dout),
    .wdata       (wdata_q),
    .rt_old      (rt_old_q),
    .load_result (load_result),
    .store_word  (store_word),
    .misaligned  (misaligned)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (misaligned)           state_nx = ST_RESP;
          else if (op_in == OP_SW)  state_nx = ST_WRITE;
          else                      state_nx = ST_READ;
        end
      end
      ST_READ:  state_nx = is_store(op_q) ? ST_WRITE : ST_RESP;
      ST_WRITE: state_nx = ST_RESP;
      ST_RESP:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= 32'd0;
      mem_wr_en  <= 1'b0;
    end else begin
      state      <= state_nx;
      mem_wr_en  <= (state_nx == ST_WRITE);
      resp_valid <= (state_nx == ST_RESP);
      resp_err   <= (state_nx == ST_RESP) && (state == ST_IDLE);
      resp_rdata <= ((state_nx == ST_RESP) && (state == ST_READ)) ? load_result : 32'd0;
      if (accept) begin
        mem_addr <= {req_addr[AW-1:2], 2'b00};
        if (op_in == OP_SW) mem_din <= req_wdata;
      end
      if ((state == ST_READ) && (state_nx == ST_WRITE)) begin
        mem_din <= store_word;
      end
    end
  end

  // Request payload latch.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q     <= op_in;
      k_q      <= req_addr[1:0];
      wdata_q  <= req_wdata;
      rt_old_q <= req_rt_old;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  localparam int AW  = 32;
  localparam int OPW = 4;

  logic           clk;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [OPW-1:0] req_op;
  logic [AW-1:0]  req_addr;
  logic [31:0]    req_wdata;
  logic [31:0]    req_rt_old;
  logic           resp_valid;
  logic [31:0]    resp_rdata;
  logic           resp_err;
  logic [AW-1:0]  mem_addr;
  logic [31:0]    mem_din;
  logic           mem_wr_en;
  logic [31:0]    mem_dout;

  logic [7:0]     dmem    [256];
  logic [7:0]     ref_mem [256];
  logic           load_fresh;
  int             wr_cnt = 0;
  logic [AW-1:0]  wr_addr;
  int             total = 0;
  int             bad = 0;
  int             cur_op = 0;

  mem_access_unit #(.AW(AW), .OPW(OPW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rt_old (req_rt_old),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_wr_en  (mem_wr_en),
    .mem_dout   (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pre_byte(input int i);
    case (i)
      128:     return 8'hf1;
      129:     return 8'h1f;
      130:     return 8'h3d;
      131:     return 8'hd3;
      default: return 8'h00;
    endcase
  endfunction

  // Memory model: combinational big-endian read, write on every edge with enable high.
  always_comb begin
    mem_dout = {dmem[{mem_addr[7:2], 2'd0}], dmem[{mem_addr[7:2], 2'd1}],
                dmem[{mem_addr[7:2], 2'd2}], dmem[{mem_addr[7:2], 2'd3}]};
  end

  always @(posedge clk) begin
    if (load_fresh) begin
      for (int i = 0; i < 256; i++) dmem[i] <= pre_byte(i);
    end else if (mem_wr_en) begin
      dmem[{mem_addr[7:2], 2'd0}] <= mem_din[31:24];
      dmem[{mem_addr[7:2], 2'd1}] <= mem_din[23:16];
      dmem[{mem_addr[7:2], 2'd2}] <= mem_din[15:8];
      dmem[{mem_addr[7:2], 2'd3}] <= mem_din[7:0];
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s op=%0d observed=%h expected=%h", tag, cur_op, obs, exp);
    end
  endtask

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  function automatic logic [31:0] dut_word(input int a);
    return {dmem[a], dmem[a+1], dmem[a+2], dmem[a+3]};
  endfunction

  task automatic fresh();
    load_fresh = 1'b1;
    @(posedge clk); #1;
    load_fresh = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pre_byte(i);
  endtask

  // Byte-lane reference: works on individual bytes of the aligned word.
  task automatic model(input logic [3:0] op_raw, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rt_old,
                       output logic [31:0] rd, output logic err,
                       output int lat, output int nwr);
    logic [3:0] op;
    logic [7:0] w [4];
    logic [7:0] d [4];
    logic [7:0] r [4];
    logic [7:0] o [4];
    int base;
    int k;
    op   = (op_raw > OP_SWR) ? OP_LW : op_raw;
    base = int'(addr[7:0]) & 32'hFC;
    k    = int'(addr[1:0]);
    for (int i = 0; i < 4; i++) begin
      w[i] = ref_mem[base + i];
      d[i] = 8'(wdata >> (24 - 8 * i));
      r[i] = 8'(rt_old >> (24 - 8 * i));
      o[i] = w[i];
    end
    rd  = 32'd0;
    nwr = 0;
    lat = 2;
    err = ((op == OP_LW || op == OP_SW) && k != 0) ||
          ((op == OP_LH || op == OP_LHU || op == OP_SH) && (k % 2) == 1);
    if (err) begin
      lat = 1;
      return;
    end
    case (op)
      OP_LB:  rd = {{24{w[k][7]}}, w[k]};
      OP_LBU: rd = {24'd0, w[k]};
      OP_LH:  rd = {{16{w[k][7]}}, w[k], w[k+1]};
      OP_LHU: rd = {16'd0, w[k], w[k+1]};
      OP_LWL: begin
        for (int j = 0; j < 4; j++) o[j] = (j + k <= 3) ? w[j+k] : r[j];
        rd = {o[0], o[1], o[2], o[3]};
      end
      OP_LWR: begin
        for (int j = 0; j < 4; j++) o[j] = (j >= 3 - k) ? w[j-(3-k)] : r[j];
        rd = {o[0], o[1], o[2], o[3]};
      end
      OP_SW:  for (int j = 0; j < 4; j++) o[j] = d[j];
      OP_SB:  o[k] = d[3];
      OP_SH:  begin o[k] = d[2]; o[k+1] = d[3]; end
      OP_SWL: for (int j = 0; j < 4; j++) o[j] = (j < k) ? w[j] : d[j-k];
      OP_SWR: for (int j = 0; j < 4; j++) o[j] = (j <= k) ? d[j+3-k] : w[j];
      default: rd = {w[0], w[1], w[2], w[3]};
    endcase
    if (op >= OP_SW) begin
      nwr = 1;
      lat = (op == OP_SW) ? 2 : 3;
      for (int j = 0; j < 4; j++) ref_mem[base + j] = o[j];
    end
  endtask

  task automatic do_req(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rt_old);
    logic [31:0] e_rd;
    logic        e_err;
    int          e_lat;
    int          e_nwr;
    int          cyc;
    int          base_wr;
    cur_op = int'(op);
    chk("ready_idle", 32'(req_ready), 32'd1);
    model(op, addr, wdata, rt_old, e_rd, e_err, e_lat, e_nwr);
    base_wr    = wr_cnt;
    req_valid  = 1'b1;
    req_op     = op;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rt_old = rt_old;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_op     = 4'($urandom());
    req_addr   = $urandom();
    req_wdata  = $urandom();
    req_rt_old = $urandom();
    chk("ready_busy", 32'(req_ready), 32'd0);
    cyc = 1;
    while (resp_valid !== 1'b1 && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("latency", 32'(cyc), 32'(e_lat));
    chk("rdata", resp_rdata, e_rd);
    chk("err", 32'(resp_err), 32'(e_err));
    @(posedge clk); #1;
    chk("resp_pulse", 32'(resp_valid), 32'd0);
    chk("write_count", 32'(wr_cnt - base_wr), 32'(e_nwr));
    if (e_nwr == 1) chk("write_addr", wr_addr, {addr[31:2], 2'b00});
    chk("mem_diff", 32'(mem_diff()), 32'd0);
  endtask

  initial begin
    int base_wr;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_rt_old = '0;
    load_fresh = 1'b0;
    fresh();
    @(posedge clk); #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_req(OP_LW,  32'd128, 32'd0, 32'd0);
    do_req(OP_LB,  32'd128, 32'd0, 32'd0);
    do_req(OP_LBU, 32'd128, 32'd0, 32'd0);
    do_req(OP_LH,  32'd130, 32'd0, 32'd0);
    do_req(OP_LB,  32'd129, 32'd0, 32'd0);
    do_req(OP_LWL, 32'd131, 32'd0, 32'h11223344);
    do_req(OP_LW,  32'd130, 32'hDEADBEEF, 32'd0);
    do_req(OP_SH,  32'd129, 32'hDEADBEEF, 32'd0);
    chk("word128_after_err", dut_word(128), 32'hf11f3dd3);

    // Reset lands while an SWL is in its read cycle.
    cur_op     = int'(OP_SWL);
    base_wr    = wr_cnt;
    req_valid  = 1'b1;
    req_op     = OP_SWL;
    req_addr   = 32'd128;
    req_wdata  = 32'hCAFEBABE;
    req_rt_old = 32'd0;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    rst        = 1'b1;
    @(posedge clk); #1;
    rst        = 1'b0;
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_rdata", resp_rdata, 32'd0);
    chk("midrst_err", 32'(resp_err), 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_mem_din", mem_din, 32'd0);
    chk("midrst_wr_en", 32'(mem_wr_en), 32'd0);
    @(posedge clk); #1;
    chk("midrst_no_write", 32'(wr_cnt - base_wr), 32'd0);
    do_req(OP_LW, 32'd128, 32'd0, 32'd0);
    chk("word128_after_rst", dut_word(128), 32'hf11f3dd3);

    do_req(OP_SB, 32'd130, 32'h000000AA, 32'd0);
    chk("word128_after_sb", dut_word(128), 32'hf11faad3);
    do_req(OP_LW, 32'd128, 32'd0, 32'd0);

    fresh();
    do_req(OP_SWR, 32'd129, 32'h12345678, 32'd0);
    chk("word128_after_swr", dut_word(128), 32'h56783dd3);

    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = $urandom();
      if (n % 3 == 0) a[7:0] = 8'(128 + $urandom_range(0, 7));
      do_req(4'($urandom_range(0, 15)), a, $urandom(), $urandom());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
